// File: rtl/ll_dequeue_arbiter.sv
// Dequeue arbiter: pops one linked list per cycle, reads its head word and buffers it in a 2-entry output FIFO.
// Define LL_DEQ_STRICT_PRIO_EN for fixed lowest-index priority instead of round-robin.
module ll_dequeue_arbiter #(
    parameter int NUM_LISTS  = 2,
    parameter int NUM_ELEMS  = 4,
    parameter int PTR_WIDTH  = $clog2(NUM_ELEMS),
    parameter int DATA_WIDTH = 8,
    parameter int LIST_WIDTH = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_LISTS-1:0]  empty,
    input  logic [PTR_WIDTH-1:0]  popped_head,
    output logic [NUM_LISTS-1:0]  pop,
    output logic                  mem_ren,
    output logic [PTR_WIDTH-1:0]  mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [LIST_WIDTH-1:0] out_list
);

    // Output handshake: a word transfers on a cycle where out_valid && out_ready;
    // out_valid never drops and out_data/out_list never change until that transfer.

    logic                  active;
    logic                  inflight;
    logic [LIST_WIDTH-1:0] inflight_list;
    logic [1:0]            fifo_count;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [LIST_WIDTH-1:0] fifo_list [2];

    logic                  fifo_wr;
    logic                  fifo_rd;
    logic [2:0]            occupancy;
    logic                  can_pop;
    logic                  found;
    logic [LIST_WIDTH-1:0] sel;

`ifndef LL_DEQ_STRICT_PRIO_EN
    logic [LIST_WIDTH-1:0] rr_ptr;
`endif

    assign fifo_wr   = inflight;
    assign fifo_rd   = out_valid & out_ready;
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
    // Buffered plus in-flight words, minus the one leaving this cycle, must leave a free slot.
    assign can_pop   = active && ((occupancy < 3'd2) || (fifo_rd && (occupancy == 3'd2)));

    always_comb begin
        found = 1'b0;
        sel   = '0;
`ifdef LL_DEQ_STRICT_PRIO_EN
        for (int i = 0; i < NUM_LISTS; i++) begin
            if (!found && !empty[i]) begin
                found = 1'b1;
                sel   = LIST_WIDTH'(i);
            end
        end
`else
        for (int off = 0; off < NUM_LISTS; off++) begin
            if (!found && !empty[(int'(rr_ptr) + off) % NUM_LISTS]) begin
                found = 1'b1;
                sel   = LIST_WIDTH'((int'(rr_ptr) + off) % NUM_LISTS);
            end
        end
`endif
    end

    always_comb begin
        pop = '0;
        if (can_pop && found) begin
            pop[sel] = 1'b1;
        end
    end

    assign mem_ren   = |pop;
    assign mem_raddr = mem_ren ? popped_head : '0;

`ifndef LL_DEQ_STRICT_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (mem_ren) begin
            if (int'(sel) == NUM_LISTS - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= sel + 1'b1;
            end
        end
    end
`endif

    // active holds pops off until the first rising edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active        <= 1'b0;
            inflight      <= 1'b0;
            inflight_list <= '0;
        end else begin
            active   <= 1'b1;
            inflight <= mem_ren;
            if (mem_ren) begin
                inflight_list <= sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_list[i] <= '0;
            end
        end else begin
            if (fifo_wr) begin
                fifo_data[wr_ptr] <= mem_rdata;
                fifo_list[wr_ptr] <= inflight_list;
                wr_ptr            <= ~wr_ptr;
            end
            if (fifo_rd) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_list  = fifo_list[rd_ptr];

endmodule

// File: tb/tb_ll_dequeue_arbiter.sv
// Bench for ll_dequeue_arbiter: table of per-cycle vectors plus reset/backpressure sequences.
// Expectations follow LL_DEQ_STRICT_PRIO_EN when it is defined.
module tb_ll_dequeue_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] empty;
    logic [1:0] popped_head;
    logic [1:0] pop;
    logic       mem_ren;
    logic [1:0] mem_raddr;
    logic [7:0] mem_rdata;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [0:0] out_list;

    int total;
    int bad;

    typedef struct {
        logic [1:0] empty;
        logic       ready;
        logic [1:0] exp_pop;
        logic [1:0] exp_raddr;
        logic       exp_valid;
        logic [0:0] exp_list;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] mem [4];

    ll_dequeue_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .empty      (empty),
        .popped_head(popped_head),
        .pop        (pop),
        .mem_ren    (mem_ren),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_list   (out_list)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // List 0 head is address 1 (word 3C), list 1 head is address 3 (word A5).
    assign popped_head = pop[1] ? 2'd3 : (pop[0] ? 2'd1 : 2'd0);

    initial begin
        mem[0]    = 8'h11;
        mem[1]    = 8'h3C;
        mem[2]    = 8'h77;
        mem[3]    = 8'hA5;
        mem_rdata = 8'h00;
    end

    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem[mem_raddr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle(input logic [1:0] e, input logic r);
        @(negedge clk);
        empty     = e;
        out_ready = r;
        #1;
    endtask

    task automatic reset_dut(input logic [1:0] e, input logic r);
        @(negedge clk);
        rst_n     = 1'b0;
        empty     = 2'b00;
        out_ready = 1'b0;
        #1;
        check("rst_pop", pop, 2'b00);
        check("rst_ren", mem_ren, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_list", out_list, 1'b0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        empty     = e;
        out_ready = r;
        #1;
        check("release_pop", pop, 2'b00);
    endtask

    task automatic add(input logic [1:0] e, input logic r, input logic [1:0] p, input logic [1:0] a,
                       input logic v, input logic [0:0] l, input logic [7:0] d);
        vec_t x;
        x.empty = e; x.ready = r; x.exp_pop = p; x.exp_raddr = a;
        x.exp_valid = v; x.exp_list = l; x.exp_data = d;
        vecs.push_back(x);
    endtask

    initial begin
        int pops;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b1;
        empty     = 2'b11;
        out_ready = 1'b0;

`ifdef LL_DEQ_STRICT_PRIO_EN
        add(2'b00, 1, 2'b01, 2'd1, 0, 1'b0, 8'h00);
        add(2'b00, 1, 2'b01, 2'd1, 0, 1'b0, 8'h00);
        add(2'b00, 1, 2'b01, 2'd1, 1, 1'b0, 8'h3C);
        add(2'b00, 1, 2'b01, 2'd1, 1, 1'b0, 8'h3C);
        add(2'b00, 1, 2'b01, 2'd1, 1, 1'b0, 8'h3C);
        add(2'b00, 0, 2'b00, 2'd0, 1, 1'b0, 8'h3C);
        add(2'b00, 0, 2'b00, 2'd0, 1, 1'b0, 8'h3C);
        add(2'b00, 0, 2'b00, 2'd0, 1, 1'b0, 8'h3C);
        add(2'b00, 1, 2'b01, 2'd1, 1, 1'b0, 8'h3C);
        add(2'b00, 1, 2'b01, 2'd1, 1, 1'b0, 8'h3C);
        add(2'b00, 1, 2'b01, 2'd1, 1, 1'b0, 8'h3C);
        add(2'b01, 1, 2'b10, 2'd3, 1, 1'b0, 8'h3C);
        add(2'b10, 1, 2'b01, 2'd1, 1, 1'b0, 8'h3C);
        add(2'b11, 1, 2'b00, 2'd0, 1, 1'b1, 8'hA5);
        add(2'b11, 1, 2'b00, 2'd0, 1, 1'b0, 8'h3C);
        add(2'b11, 1, 2'b00, 2'd0, 0, 1'b0, 8'h00);
`else
        add(2'b00, 1, 2'b01, 2'd1, 0, 1'b0, 8'h00);
        add(2'b00, 1, 2'b10, 2'd3, 0, 1'b0, 8'h00);
        add(2'b00, 1, 2'b01, 2'd1, 1, 1'b0, 8'h3C);
        add(2'b00, 1, 2'b10, 2'd3, 1, 1'b1, 8'hA5);
        add(2'b00, 1, 2'b01, 2'd1, 1, 1'b0, 8'h3C);
        add(2'b00, 0, 2'b00, 2'd0, 1, 1'b1, 8'hA5);
        add(2'b00, 0, 2'b00, 2'd0, 1, 1'b1, 8'hA5);
        add(2'b00, 0, 2'b00, 2'd0, 1, 1'b1, 8'hA5);
        add(2'b00, 1, 2'b10, 2'd3, 1, 1'b1, 8'hA5);
        add(2'b00, 1, 2'b01, 2'd1, 1, 1'b0, 8'h3C);
        add(2'b00, 1, 2'b10, 2'd3, 1, 1'b1, 8'hA5);
        add(2'b01, 1, 2'b10, 2'd3, 1, 1'b0, 8'h3C);
        add(2'b10, 1, 2'b01, 2'd1, 1, 1'b1, 8'hA5);
        add(2'b11, 1, 2'b00, 2'd0, 1, 1'b1, 8'hA5);
        add(2'b11, 1, 2'b00, 2'd0, 1, 1'b0, 8'h3C);
        add(2'b11, 1, 2'b00, 2'd0, 0, 1'b0, 8'h00);
`endif

        // Table run: starts on the cycle after reset release.
        reset_dut(2'b00, 1'b1);
        for (int i = 0; i < vecs.size(); i++) begin
            next_cycle(vecs[i].empty, vecs[i].ready);
            check($sformatf("v%0d_pop", i), pop, vecs[i].exp_pop);
            check($sformatf("v%0d_ren", i), mem_ren, |vecs[i].exp_pop);
            check($sformatf("v%0d_raddr", i), mem_raddr, vecs[i].exp_raddr);
            check($sformatf("v%0d_valid", i), out_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_list", i), out_list, vecs[i].exp_list);
                check($sformatf("v%0d_data", i), out_data, vecs[i].exp_data);
            end
        end

        // Backpressure from a fresh start: exactly two pops, head word held.
        reset_dut(2'b00, 1'b0);
        pops = 0;
        for (int c = 1; c <= 6; c++) begin
            next_cycle(2'b00, 1'b0);
            if (pop != 2'b00) pops++;
            if (c >= 3) begin
                check($sformatf("bp%0d_valid", c), out_valid, 1'b1);
                check($sformatf("bp%0d_data", c), out_data, 8'h3C);
                check($sformatf("bp%0d_list", c), out_list, 1'b0);
            end
        end
        check("bp_pop_count", pops, 2);

        next_cycle(2'b11, 1'b1);
        check("drain1_valid", out_valid, 1'b1);
        check("drain1_data", out_data, 8'h3C);
        check("drain1_pop", pop, 2'b00);
        next_cycle(2'b11, 1'b1);
        check("drain2_valid", out_valid, 1'b1);
`ifdef LL_DEQ_STRICT_PRIO_EN
        check("drain2_data", out_data, 8'h3C);
        check("drain2_list", out_list, 1'b0);
`else
        check("drain2_data", out_data, 8'hA5);
        check("drain2_list", out_list, 1'b1);
`endif
        next_cycle(2'b11, 1'b1);
        check("drained_valid", out_valid, 1'b0);
        next_cycle(2'b00, 1'b1);
        check("resume_pop", pop, 2'b01);

        // Fill the FIFO, then reset asynchronously in the middle of a cycle.
        next_cycle(2'b00, 1'b0);
        next_cycle(2'b00, 1'b0);
        next_cycle(2'b00, 1'b0);
        check("full_valid", out_valid, 1'b1);
        check("full_pop", pop, 2'b00);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_data", out_data, 8'h00);
        check("async_rst_pop", pop, 2'b00);
        @(negedge clk);
        rst_n     = 1'b1;
        empty     = 2'b11;
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            next_cycle(2'b11, 1'b1);
            check($sformatf("stale%0d_valid", c), out_valid, 1'b0);
            check($sformatf("stale%0d_pop", c), pop, 2'b00);
        end

        // Single-list availability after reset.
        reset_dut(2'b01, 1'b1);
        next_cycle(2'b01, 1'b1);
        check("only_l1_pop", pop, 2'b10);
        check("only_l1_raddr", mem_raddr, 2'd3);
        next_cycle(2'b01, 1'b1);
        check("only_l1_pop2", pop, 2'b10);
        next_cycle(2'b10, 1'b1);
        check("only_l0_pop", pop, 2'b01);
        check("only_l0_list", out_list, 1'b1);
        check("only_l0_data", out_data, 8'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
